// File: rtl/alu_dispatcher.sv
// Initiator for the shared ALU slice bus: runs the enabled-reset clear sequence,
// issues one operation at a time and returns the selected slice result on a valid/ready port.
//
// state   | meaning
// --------+---------------------------------------------------------------
// INIT    | enabled-reset pulse on the slice bus (entered from rst)
// CLEAR   | bus idle for one settle cycle after the clear pulse
// IDLE    | waiting for a request, req_ready=1
// ISSUE   | alu_en=1 with latched op/A/B, slices capture at the closing edge
// CAPTURE | bus quiet, selected slice result registered at the closing edge
// RESP    | rsp_valid=1 until rsp_ready

module alu_dispatcher #(
  parameter int DATA_W  = 3,
  parameter int RES_W   = 6,
  parameter int NUM_OPS = 4,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_op,
  input  logic [DATA_W-1:0]        req_a,
  input  logic [DATA_W-1:0]        req_b,
  output logic [1:0]               alu_op,
  output logic                     alu_en,
  output logic                     alu_rst_n,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  input  logic [NUM_OPS*RES_W-1:0] alu_res,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [RES_W-1:0]         rsp_data,
  output logic [1:0]               rsp_op,
  output logic                     busy,
  output logic [CNT_W-1:0]         op_count
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_CLEAR,
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_RESP
  } state_t;

  state_t           state;
  logic             init_sent;
  logic [RES_W-1:0] sel_res;

  // The bus registers double as the operation latch; out-of-range ops select 0.
  always_comb begin
    sel_res = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      if (int'(alu_op) == k) sel_res = alu_res[k*RES_W +: RES_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INIT;
      init_sent <= 1'b0;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      alu_en    <= 1'b0;
      alu_rst_n <= 1'b1;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_op    <= '0;
      op_count  <= '0;
    end else begin
      case (state)
        // First edge after reset drives the clear pulse, second edge ends it.
        ST_INIT: begin
          busy <= 1'b1;
          if (!init_sent) begin
            init_sent <= 1'b1;
            alu_en    <= 1'b1;
            alu_rst_n <= 1'b0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
          end else begin
            alu_en    <= 1'b0;
            alu_rst_n <= 1'b1;
            state     <= ST_CLEAR;
          end
        end

        ST_CLEAR: begin
          init_sent <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end

        ST_IDLE: begin
          if (req_valid) begin
            alu_op    <= req_op;
            alu_a     <= req_a;
            alu_b     <= req_b;
            alu_en    <= 1'b1;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          alu_en <= 1'b0;
          state  <= ST_CAPTURE;
        end

        ST_CAPTURE: begin
          rsp_data  <= sel_res;
          rsp_op    <= alu_op;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + CNT_W'(1);
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state     <= ST_INIT;
          init_sent <= 1'b0;
          alu_en    <= 1'b0;
          alu_rst_n <= 1'b1;
          req_ready <= 1'b0;
          rsp_valid <= 1'b0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_dispatcher.sv
// Bench for alu_dispatcher: behavioural slice models on the bus and a
// transaction-level reference for results, latency and the completion count.

module tb_alu_dispatcher;
  localparam int DATA_W  = 3;
  localparam int RES_W   = 6;
  localparam int NUM_OPS = 4;
  localparam int CNT_W   = 8;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     req_valid = 1'b0;
  logic                     req_ready;
  logic [1:0]               req_op = '0;
  logic [DATA_W-1:0]        req_a = '0;
  logic [DATA_W-1:0]        req_b = '0;
  logic [1:0]               alu_op;
  logic                     alu_en;
  logic                     alu_rst_n;
  logic [DATA_W-1:0]        alu_a;
  logic [DATA_W-1:0]        alu_b;
  logic [NUM_OPS*RES_W-1:0] alu_res;
  logic                     rsp_valid;
  logic                     rsp_ready = 1'b0;
  logic [RES_W-1:0]         rsp_data;
  logic [1:0]               rsp_op;
  logic                     busy;
  logic [CNT_W-1:0]         op_count;

  logic [NUM_OPS-1:0][RES_W-1:0] slice_q;
  bit const_mode = 1'b0;
  int en_cycles = 0;
  int n_checks = 0;
  int n_fail = 0;
  int exp_count = 0;

  alu_dispatcher #(.DATA_W(DATA_W), .RES_W(RES_W), .NUM_OPS(NUM_OPS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_op(alu_op), .alu_en(alu_en), .alu_rst_n(alu_rst_n), .alu_a(alu_a), .alu_b(alu_b),
    .alu_res(alu_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_op(rsp_op),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Slice k's function: 0 is XNOR, others arithmetic or fixed tags in const_mode.
  function automatic logic [RES_W-1:0] ref_fn(input logic [1:0] op, input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b, input bit cm);
    case (op)
      2'd0:    return {3'b000, ~(a ^ b)};
      2'd1:    return cm ? 6'h11 : 6'(a) + 6'(b);
      2'd2:    return cm ? 6'h22 : 6'(a) * 6'(b);
      default: return cm ? 6'h33 : {a, b};
    endcase
  endfunction

  // Registered slices: clear or capture only while the bus enable is high.
  always @(posedge clk) begin
    if (alu_en) begin
      en_cycles++;
      if (!alu_rst_n) slice_q <= '0;
      else for (int k = 0; k < NUM_OPS; k++) slice_q[k] <= ref_fn(2'(k), alu_a, alu_b, const_mode);
    end
  end
  assign alu_res = slice_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        output logic [RES_W-1:0] data, output logic [1:0] rop, output int lat,
                        output logic en_seen, output logic [DATA_W-1:0] bus_a, output logic [DATA_W-1:0] bus_b);
    int w = 0;
    while (!req_ready && w < 20) begin tick(); w++; end
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_op = 2'($urandom); req_a = 3'($urandom); req_b = 3'($urandom);
    en_seen = alu_en; bus_a = alu_a; bus_b = alu_b;
    lat = 0;
    while (!rsp_valid && lat < 20) begin tick(); lat++; end
    data = rsp_data; rop = rsp_op;
    if (!rsp_valid) lat = -1;
  endtask

  task automatic accept_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_checks++; if (alu_en !== 1'b0) begin n_fail++; $display("FAIL rst_alu_en got %b want 0", alu_en); end
    n_checks++; if (alu_rst_n !== 1'b1) begin n_fail++; $display("FAIL rst_alu_rst_n got %b want 1", alu_rst_n); end
    n_checks++; if ({req_ready, rsp_valid, busy} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got %b want 000", {req_ready, rsp_valid, busy}); end
    n_checks++; if (op_count !== 8'd0) begin n_fail++; $display("FAIL rst_op_count got %0d want 0", op_count); end
    rst = 1'b0;
    tick();
    n_checks++; if ({alu_en, alu_rst_n} !== 2'b10) begin n_fail++; $display("FAIL init_pulse got en/rstn %b want 10", {alu_en, alu_rst_n}); end
    n_checks++; if ({alu_a, alu_b, alu_op} !== 8'd0) begin n_fail++; $display("FAIL init_bus got %h want 0", {alu_a, alu_b, alu_op}); end
    tick();
    n_checks++; if ({alu_en, alu_rst_n, req_ready} !== 3'b010) begin n_fail++; $display("FAIL clear_cycle got en/rstn/rdy %b want 010", {alu_en, alu_rst_n, req_ready}); end
    tick();
    n_checks++; if ({req_ready, busy, rsp_valid} !== 3'b100) begin n_fail++; $display("FAIL idle_flags got rdy/busy/vld %b want 100", {req_ready, busy, rsp_valid}); end
    n_checks++; if (slice_q !== '0) begin n_fail++; $display("FAIL slices_cleared got %h want 0", slice_q); end
    exp_count = 0;
  endtask

  task automatic test_xnor();
    logic [RES_W-1:0] d; logic [1:0] ro; int lat; logic en; logic [DATA_W-1:0] ba, bb;
    int e0;
    const_mode = 1'b0;
    e0 = en_cycles;
    run_op(2'd0, 3'b101, 3'b011, d, ro, lat, en, ba, bb);
    n_checks++; if ({en, ba, bb} !== 7'b1_101_011) begin n_fail++; $display("FAIL xnor_issue got en/a/b %b want 1101011", {en, ba, bb}); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL xnor_latency got %0d want 2", lat); end
    n_checks++; if (d !== 6'b000001) begin n_fail++; $display("FAIL xnor_data got %b want 000001", d); end
    n_checks++; if (ro !== 2'd0) begin n_fail++; $display("FAIL xnor_op got %0d want 0", ro); end
    accept_rsp();
    exp_count = (exp_count + 1) % 256;
    n_checks++; if (en_cycles - e0 !== 1) begin n_fail++; $display("FAIL xnor_en_pulses got %0d want 1", en_cycles - e0); end
    n_checks++; if (op_count !== CNT_W'(exp_count)) begin n_fail++; $display("FAIL xnor_count got %0d want %0d", op_count, exp_count); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL back_to_back_ready got %b want 1", req_ready); end
  endtask

  task automatic test_const_slices();
    logic [RES_W-1:0] d; logic [1:0] ro; int lat; logic en; logic [DATA_W-1:0] ba, bb;
    logic [DATA_W-1:0] a, b;
    const_mode = 1'b1;
    for (int op = 1; op < 4; op++) begin
      a = 3'($urandom); b = 3'($urandom);
      run_op(2'(op), a, b, d, ro, lat, en, ba, bb);
      n_checks++; if (d !== ref_fn(2'(op), a, b, 1'b1)) begin n_fail++; $display("FAIL const_data op%0d got %h want %h", op, d, ref_fn(2'(op), a, b, 1'b1)); end
      n_checks++; if (ro !== 2'(op)) begin n_fail++; $display("FAIL const_op got %0d want %0d", ro, op); end
      accept_rsp();
      exp_count = (exp_count + 1) % 256;
      n_checks++; if (op_count !== CNT_W'(exp_count)) begin n_fail++; $display("FAIL const_count got %0d want %0d", op_count, exp_count); end
    end
    const_mode = 1'b0;
  endtask

  task automatic test_hold();
    logic [RES_W-1:0] d, want; logic [1:0] ro; int lat; logic en; logic [DATA_W-1:0] ba, bb;
    logic [1:0] op; logic [DATA_W-1:0] a, b;
    logic [NUM_OPS-1:0][RES_W-1:0] snap;
    int e0;
    op = 2'($urandom); a = 3'($urandom); b = 3'($urandom);
    want = ref_fn(op, a, b, 1'b0);
    run_op(op, a, b, d, ro, lat, en, ba, bb);
    e0 = en_cycles; snap = slice_q;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'($urandom); req_op = 2'($urandom); req_a = 3'($urandom); req_b = 3'($urandom);
      tick();
      n_checks++; if ({rsp_valid, req_ready, rsp_data} !== {2'b10, want}) begin n_fail++; $display("FAIL hold_cycle%0d got vld/rdy/data %b/%b/%h want 1/0/%h", i, rsp_valid, req_ready, rsp_data, want); end
    end
    req_valid = 1'b0;
    n_checks++; if (en_cycles != e0) begin n_fail++; $display("FAIL hold_en_pulses got %0d want 0", en_cycles - e0); end
    n_checks++; if (slice_q !== snap) begin n_fail++; $display("FAIL hold_slices got %h want %h", slice_q, snap); end
    accept_rsp();
    exp_count = (exp_count + 1) % 256;
    rsp_ready = 1'b1;
    repeat (3) tick();
    rsp_ready = 1'b0;
    n_checks++; if (op_count !== CNT_W'(exp_count)) begin n_fail++; $display("FAIL idle_rsp_ready_count got %0d want %0d", op_count, exp_count); end
    n_checks++; if ({rsp_valid, req_ready} !== 2'b01) begin n_fail++; $display("FAIL idle_after_hold got vld/rdy %b want 01", {rsp_valid, req_ready}); end
  endtask

  task automatic test_random();
    logic [RES_W-1:0] d; logic [1:0] ro; int lat; logic en; logic [DATA_W-1:0] ba, bb;
    logic [1:0] op; logic [DATA_W-1:0] a, b;
    int hold;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom); a = 3'($urandom); b = 3'($urandom); hold = int'($urandom_range(3, 0));
      run_op(op, a, b, d, ro, lat, en, ba, bb);
      n_checks++; if ({lat == 2, d, ro} !== {1'b1, ref_fn(op, a, b, 1'b0), op}) begin n_fail++; $display("FAIL rand%0d got lat/data/op %0d/%h/%0d want 2/%h/%0d", i, lat, d, ro, ref_fn(op, a, b, 1'b0), op); end
      repeat (hold) tick();
      accept_rsp();
      exp_count = (exp_count + 1) % 256;
      n_checks++; if (op_count !== CNT_W'(exp_count)) begin n_fail++; $display("FAIL rand_count got %0d want %0d", op_count, exp_count); end
    end
  endtask

  task automatic test_reset_mid();
    int w = 0;
    while (!req_ready && w < 20) begin tick(); w++; end
    req_op = 2'd3; req_a = 3'b111; req_b = 3'b110; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    n_checks++; if ({alu_en, busy, req_ready, rsp_valid} !== 4'b0000) begin n_fail++; $display("FAIL midrst_flags got %b want 0000", {alu_en, busy, req_ready, rsp_valid}); end
    n_checks++; if ({alu_a, alu_b, alu_rst_n} !== 7'b000_000_1) begin n_fail++; $display("FAIL midrst_bus got %b want 0000001", {alu_a, alu_b, alu_rst_n}); end
    n_checks++; if (op_count !== 8'd0) begin n_fail++; $display("FAIL midrst_count got %0d want 0", op_count); end
    exp_count = 0;
    tick();
    rst = 1'b0;
    tick();
    n_checks++; if ({alu_en, alu_rst_n, rsp_valid} !== 3'b100) begin n_fail++; $display("FAIL midrst_init got %b want 100", {alu_en, alu_rst_n, rsp_valid}); end
    tick();
    n_checks++; if ({alu_en, alu_rst_n, rsp_valid} !== 3'b010) begin n_fail++; $display("FAIL midrst_clear got %b want 010", {alu_en, alu_rst_n, rsp_valid}); end
    tick();
    n_checks++; if ({req_ready, rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL midrst_idle got %b want 10", {req_ready, rsp_valid}); end
  endtask

  task automatic test_wrap();
    logic [RES_W-1:0] d; logic [1:0] ro; int lat; logic en; logic [DATA_W-1:0] ba, bb;
    for (int i = 0; i < 255; i++) begin
      run_op(2'($urandom), 3'($urandom), 3'($urandom), d, ro, lat, en, ba, bb);
      accept_rsp();
      exp_count = (exp_count + 1) % 256;
    end
    n_checks++; if (op_count !== CNT_W'(exp_count)) begin n_fail++; $display("FAIL wrap_pre got %0d want %0d", op_count, exp_count); end
    run_op(2'd1, 3'd2, 3'd5, d, ro, lat, en, ba, bb);
    accept_rsp();
    exp_count = (exp_count + 1) % 256;
    n_checks++; if (op_count !== CNT_W'(exp_count)) begin n_fail++; $display("FAIL wrap_post got %0d want %0d", op_count, exp_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_xnor();
    test_const_slices();
    test_hold();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
